// File: rtl/io_mmio_pkg.sv
// io_mmio_pkg: register offsets, TCTRL bit positions and the seven-segment
// glyph table shared by the io_mmio controller.
package io_mmio_pkg;

  // Word offsets inside the 32-byte window (io_addr[4:2])
  localparam logic [2:0] OFF_HEX      = 3'd0;
  localparam logic [2:0] OFF_BLANK    = 3'd1;
  localparam logic [2:0] OFF_LED      = 3'd2;
  localparam logic [2:0] OFF_KEY      = 3'd3;
  localparam logic [2:0] OFF_KEY_EDGE = 3'd4;
  localparam logic [2:0] OFF_TCOUNT   = 3'd5;
  localparam logic [2:0] OFF_TCMP     = 3'd6;
  localparam logic [2:0] OFF_TCTRL    = 3'd7;

  // TCTRL bit positions
  localparam int TCTRL_EN    = 0;
  localparam int TCTRL_AUTO  = 1;
  localparam int TCTRL_IEN   = 2;
  localparam int TCTRL_MATCH = 3;

  // Active-low segments {g,f,e,d,c,b,a} for hex values 0..F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Glyph for one digit; a blanked digit turns every segment off
  function automatic logic [6:0] seg_decode(input logic [3:0] value, input logic blank);
    logic [6:0] seg;
    if (blank) begin
      seg = 7'b1111111;
    end else begin
      seg = SEG_TABLE[value];
    end
    return seg;
  endfunction

endpackage

// File: rtl/io_mmio_key_debounce.sv
// key_debounce: two-flop synchroniser plus stability counter for one
// active-low push-button. 'state' is 1 while the key is accepted as pressed;
// 'rise' is high in the cycle whose clock edge sets 'state' to 1.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic state,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The toggle happens on the DEBOUNCE_CYCLES-th consecutive differing sample
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             state_next;

  // Synchronise the raw button; reset value means "released"
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ~key_n;
      sync2 <= sync1;
    end
  end

  // Count consecutive samples that disagree with the debounced state
  always_comb begin
    cnt_next   = cnt;
    state_next = state;
    rise       = 1'b0;
    if (sync2 == state) begin
      cnt_next = '0;
    end else if (cnt == CNT_LAST) begin
      state_next = ~state;
      cnt_next   = '0;
      rise       = sync2;
    end else begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  // Debounce counter and accepted key state
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      state <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      state <= state_next;
    end
  end

endmodule

// File: rtl/io_mmio.sv
// io_mmio: memory-mapped hex display / LED / push-button controller with a
// registered read port. The compare timer (TCOUNT/TCMP/TCTRL and its irq
// term) is built only when IO_MMIO_TIMER_EN is defined; otherwise those
// offsets read 0 and ignore writes.
module io_mmio
  import io_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0100,
  parameter int          HEX_DIGITS      = 4,
  parameter int          LEDR_W          = 18,
  parameter int          LEDG_W          = 8,
  parameter int          KEY_W           = 4,
  parameter int          DEBOUNCE_CYCLES = 50000
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [31:0]                io_addr,
  input  logic [31:0]                io_data_in,
  input  logic                       io_w_en,
  input  logic                       io_r_en,
  output logic                       io_hit,
  output logic [31:0]                io_data_out,
  input  logic [KEY_W-1:0]           key_n,
  output logic [7*HEX_DIGITS-1:0]    seven_seg_out,
  output logic [LEDR_W+LEDG_W-1:0]   led_out,
  output logic                       irq
);

  localparam int HEX_W = 4 * HEX_DIGITS;
  localparam int LED_W = LEDR_W + LEDG_W;
  localparam int SEG_W = 7 * HEX_DIGITS;

  logic [2:0]       off;
  logic             wr_en;
  logic             rd_en;
  logic [HEX_W-1:0] hex_val;
  logic [HEX_DIGITS-1:0] blank;
  logic [LED_W-1:0] led;
  logic [KEY_W-1:0] key_state;
  logic [KEY_W-1:0] key_rise;
  logic [KEY_W-1:0] key_edge;
  logic [KEY_W-1:0] key_mask;
  logic [KEY_W-1:0] edge_next;
  logic [KEY_W-1:0] mask_next;
  logic             timer_irq_next;
  logic             irq_next;
  logic [31:0]      rd_data;
  logic [SEG_W-1:0] seg_next;
  logic             unused_bits;

  // Byte lane and sub-word address bits carry no meaning for word accesses
  assign unused_bits = ^{io_addr[1:0], io_data_in};

  assign io_hit = (io_addr[31:5] == BASE_ADDR[31:5]);
  assign off    = io_addr[4:2];
  assign wr_en  = io_w_en && io_hit;
  assign rd_en  = io_r_en && io_hit;

  for (genvar k = 0; k < KEY_W; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (CLK),
      .rst  (RST),
      .key_n(key_n[k]),
      .state(key_state[k]),
      .rise (key_rise[k])
    );
  end

`ifdef IO_MMIO_TIMER_EN
  logic [31:0] tcount;
  logic [31:0] tcmp;
  logic        ten;
  logic        tauto;
  logic        tien;
  logic        tmatch;
  logic [31:0] tcount_next;
  logic        tmatch_next;
  logic        tien_next;
  logic        match_now;

  // Timer next state: software TCOUNT write beats increment/reload, a match beats W1C
  always_comb begin
    match_now   = ten && (tcount == tcmp);
    tcount_next = tcount;
    tmatch_next = tmatch;
    tien_next   = tien;
    if (wr_en && (off == OFF_TCOUNT)) begin
      tcount_next = io_data_in;
    end else if (ten) begin
      if (match_now && tauto) begin
        tcount_next = 32'h0000_0000;
      end else begin
        tcount_next = tcount + 32'h0000_0001;
      end
    end else begin
      tcount_next = tcount;
    end
    if (wr_en && (off == OFF_TCTRL)) begin
      tien_next = io_data_in[TCTRL_IEN];
    end else begin
      tien_next = tien;
    end
    if (match_now) begin
      tmatch_next = 1'b1;
    end else if (wr_en && (off == OFF_TCTRL) && io_data_in[TCTRL_MATCH]) begin
      tmatch_next = 1'b0;
    end else begin
      tmatch_next = tmatch;
    end
    timer_irq_next = tmatch_next && tien_next;
  end

  // Timer registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      tcount <= 32'h0000_0000;
      tcmp   <= 32'hFFFF_FFFF;
      ten    <= 1'b0;
      tauto  <= 1'b0;
      tien   <= 1'b0;
      tmatch <= 1'b0;
    end else begin
      tcount <= tcount_next;
      tmatch <= tmatch_next;
      tien   <= tien_next;
      if (wr_en && (off == OFF_TCMP)) begin
        tcmp <= io_data_in;
      end
      if (wr_en && (off == OFF_TCTRL)) begin
        ten   <= io_data_in[TCTRL_EN];
        tauto <= io_data_in[TCTRL_AUTO];
      end
    end
  end
`else
  // Without the timer its interrupt term is tied off
  always_comb begin
    timer_irq_next = 1'b0;
  end
`endif

  // Edge flags and mask next state; a new press beats a W1C in the same cycle
  always_comb begin
    edge_next = key_edge;
    mask_next = key_mask;
    if (wr_en && (off == OFF_KEY_EDGE)) begin
      edge_next = key_edge & ~io_data_in[KEY_W-1:0];
      mask_next = io_data_in[8 +: KEY_W];
    end else begin
      edge_next = key_edge;
      mask_next = key_mask;
    end
    edge_next = edge_next | key_rise;
    irq_next  = (|(edge_next & mask_next)) | timer_irq_next;
  end

  // Read mux; unused bits and unmapped offsets return 0
  always_comb begin
    rd_data = 32'h0000_0000;
    case (off)
      OFF_HEX:      rd_data[HEX_W-1:0] = hex_val;
      OFF_BLANK:    rd_data[HEX_DIGITS-1:0] = blank;
      OFF_LED:      rd_data[LED_W-1:0] = led;
      OFF_KEY:      rd_data[KEY_W-1:0] = key_state;
      OFF_KEY_EDGE: begin
        rd_data[KEY_W-1:0]  = key_edge;
        rd_data[8 +: KEY_W] = key_mask;
      end
`ifdef IO_MMIO_TIMER_EN
      OFF_TCOUNT:   rd_data = tcount;
      OFF_TCMP:     rd_data = tcmp;
      OFF_TCTRL:    rd_data[3:0] = {tmatch, tien, tauto, ten};
`endif
      default:      rd_data = 32'h0000_0000;
    endcase
  end

  // Per-digit segment decode from the committed HEX/BLANK registers
  always_comb begin
    seg_next = '1;
    for (int i = 0; i < HEX_DIGITS; i++) begin
      seg_next[7*i +: 7] = seg_decode(hex_val[4*i +: 4], blank[i]);
    end
  end

  // Software-visible registers, key flags, registered outputs and read data
  always_ff @(posedge CLK) begin
    if (RST) begin
      hex_val       <= '0;
      blank         <= '1;
      led           <= '0;
      key_edge      <= '0;
      key_mask      <= '0;
      irq           <= 1'b0;
      seven_seg_out <= '1;
      led_out       <= '0;
      io_data_out   <= 32'h0000_0000;
    end else begin
      if (wr_en && (off == OFF_HEX)) begin
        hex_val <= io_data_in[HEX_W-1:0];
      end
      if (wr_en && (off == OFF_BLANK)) begin
        blank <= io_data_in[HEX_DIGITS-1:0];
      end
      if (wr_en && (off == OFF_LED)) begin
        led <= io_data_in[LED_W-1:0];
      end
      key_edge      <= edge_next;
      key_mask      <= mask_next;
      irq           <= irq_next;
      seven_seg_out <= seg_next;
      led_out       <= led;
      if (rd_en) begin
        io_data_out <= rd_data;
      end else if (io_r_en) begin
        io_data_out <= 32'h0000_0000;
      end
    end
  end

endmodule

// File: tb/tb_io_mmio.sv
// tb_io_mmio: self-checking bench for io_mmio (DEBOUNCE_CYCLES = 4). Timer
// checks follow IO_MMIO_TIMER_EN the same way the design does.
module tb_io_mmio;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int D = 4;
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] io_addr = 32'h0;
  logic [31:0] io_data_in = 32'h0;
  logic        io_w_en = 1'b0;
  logic        io_r_en = 1'b0;
  logic        io_hit;
  logic [31:0] io_data_out;
  logic [3:0]  key_n = 4'hF;
  logic [27:0] seven_seg_out;
  logic [25:0] led_out;
  logic        irq;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;

  // reference model of the software-visible state
  logic [31:0] m_hex;
  logic [3:0]  m_blank;
  logic [25:0] m_led;
  logic [3:0]  m_edge;
  logic [3:0]  m_mask;

  io_mmio #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(D)) dut (
    .CLK(CLK), .RST(RST), .io_addr(io_addr), .io_data_in(io_data_in),
    .io_w_en(io_w_en), .io_r_en(io_r_en), .io_hit(io_hit),
    .io_data_out(io_data_out), .key_n(key_n), .seven_seg_out(seven_seg_out),
    .led_out(led_out), .irq(irq)
  );

  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_addr = a; io_data_in = d; io_w_en = 1'b1;
    tick();
    io_w_en = 1'b0; io_addr = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    io_addr = a; io_r_en = 1'b1;
    tick();
    io_r_en = 1'b0; io_addr = 32'h0;
    d = io_data_out;
  endtask

  function automatic logic [27:0] exp_segs();
    logic [27:0] s;
    logic [3:0]  nib;
    for (int i = 0; i < 4; i++) begin
      nib = m_hex[4*i +: 4];
      s[7*i +: 7] = m_blank[i] ? 7'h7F : GLYPH[nib];
    end
    return s;
  endfunction

  function automatic logic [31:0] model_read(input int o);
    case (o)
      0: return {16'h0, m_hex[15:0]};
      1: return {28'h0, m_blank};
      2: return {6'h0, m_led};
      4: return {20'h0, m_mask, 4'h0, m_edge};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_hex = 32'h0; m_blank = 4'hF; m_led = 26'h0; m_edge = 4'h0; m_mask = 4'h0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    RST = 1'b1; tick(); tick(); RST = 1'b0;
    model_reset();
    chk_cnt++; if (seven_seg_out !== 28'hFFFFFFF) $display("FAIL rst_seg got=%h exp=%h", seven_seg_out, 28'hFFFFFFF); else pass_cnt++;
    chk_cnt++; if (led_out !== 26'h0) $display("FAIL rst_led got=%h exp=0", led_out); else pass_cnt++;
    chk_cnt++; if (io_data_out !== 32'h0) $display("FAIL rst_dout got=%h exp=0", io_data_out); else pass_cnt++;
    chk_cnt++; if (irq !== 1'b0) $display("FAIL rst_irq got=%b exp=0", irq); else pass_cnt++;
    for (int o = 0; o < 5; o++) begin
      rd(BASE + 32'(4*o), d);
      chk_cnt++; if (d !== model_read(o)) $display("FAIL rst_read off=%0d got=%h exp=%h", o, d, model_read(o)); else pass_cnt++;
    end
    rd(BASE + 32'h18, d);
`ifdef IO_MMIO_TIMER_EN
    chk_cnt++; if (d !== 32'hFFFFFFFF) $display("FAIL rst_tcmp got=%h exp=ffffffff", d); else pass_cnt++;
`else
    chk_cnt++; if (d !== 32'h0) $display("FAIL rst_tcmp got=%h exp=0", d); else pass_cnt++;
`endif
  endtask

  task automatic test_hex();
    logic [31:0] d;
    wr(BASE + 32'h4, 32'h0); m_blank = 4'h0;
    wr(BASE, 32'h4321); m_hex = 32'h4321;
    tick();
    chk_cnt++; if (seven_seg_out !== exp_segs()) $display("FAIL hex_seg got=%h exp=%h", seven_seg_out, exp_segs()); else pass_cnt++;
    chk_cnt++; if (seven_seg_out[6:0] !== 7'b1111001) $display("FAIL hex_digit0 got=%b exp=1111001", seven_seg_out[6:0]); else pass_cnt++;
    rd(BASE, d);
    chk_cnt++; if (d !== 32'h4321) $display("FAIL hex_read got=%h exp=00004321", d); else pass_cnt++;
    for (int it = 0; it < 8; it++) begin
      m_hex = $urandom; m_blank = 4'($urandom_range(0, 15));
      wr(BASE, m_hex);
      wr(BASE + 32'h4, {$urandom_range(0, 32'hFFFFFFF), m_blank});
      tick();
      chk_cnt++; if (seven_seg_out !== exp_segs()) $display("FAIL hex_rand_seg got=%h exp=%h", seven_seg_out, exp_segs()); else pass_cnt++;
      rd(BASE, d);
      chk_cnt++; if (d !== model_read(0)) $display("FAIL hex_rand_read got=%h exp=%h", d, model_read(0)); else pass_cnt++;
      rd(BASE + 32'h4, d);
      chk_cnt++; if (d !== model_read(1)) $display("FAIL blank_rand_read got=%h exp=%h", d, model_read(1)); else pass_cnt++;
    end
  endtask

  task automatic test_led();
    logic [31:0] d;
    logic [31:0] v;
    wr(BASE + 32'h8, 32'hFFFFFFFF); m_led = 26'h3FFFFFF;
    tick();
    chk_cnt++; if (led_out !== 26'h3FFFFFF) $display("FAIL led_all got=%h exp=3ffffff", led_out); else pass_cnt++;
    io_addr = BASE + 32'h20; #1;
    chk_cnt++; if (io_hit !== 1'b0) $display("FAIL hit_above got=%b exp=0", io_hit); else pass_cnt++;
    io_addr = BASE - 32'h4; #1;
    chk_cnt++; if (io_hit !== 1'b0) $display("FAIL hit_below got=%b exp=0", io_hit); else pass_cnt++;
    io_addr = BASE + 32'h1F; #1;
    chk_cnt++; if (io_hit !== 1'b1) $display("FAIL hit_top got=%b exp=1", io_hit); else pass_cnt++;
    wr(BASE + 32'h20, 32'h0); wr(BASE + 32'h28, 32'h0);
    tick();
    chk_cnt++; if (led_out !== m_led) $display("FAIL led_outside got=%h exp=%h", led_out, m_led); else pass_cnt++;
    wr(BASE + 32'hC, 32'hF); // KEY is read-only
    rd(BASE + 32'hC, d);
    chk_cnt++; if (d !== 32'h0) $display("FAIL key_ro got=%h exp=0", d); else pass_cnt++;
    rd(BASE + 32'h20, d);
    chk_cnt++; if (d !== 32'h0) $display("FAIL read_outside got=%h exp=0", d); else pass_cnt++;
    for (int it = 0; it < 6; it++) begin
      v = $urandom; m_led = v[25:0];
      wr(BASE + 32'h8, v);
      tick();
      chk_cnt++; if (led_out !== m_led) $display("FAIL led_rand got=%h exp=%h", led_out, m_led); else pass_cnt++;
      rd(BASE + 32'h8, d);
      chk_cnt++; if (d !== model_read(2)) $display("FAIL led_rand_read got=%h exp=%h", d, model_read(2)); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    io_r_en = 1'b1;
    for (int it = 0; it < 6; it++) begin
      int o = it % 3;
      io_addr = BASE + 32'(4*o);
      e = model_read(o);
      tick();
      chk_cnt++; if (io_data_out !== e) $display("FAIL b2b_read off=%0d got=%h exp=%h", o, io_data_out, e); else pass_cnt++;
    end
    io_r_en = 1'b0; io_addr = 32'h0;
    tick();
    chk_cnt++; if (io_data_out !== model_read(2)) $display("FAIL read_hold got=%h exp=%h", io_data_out, model_read(2)); else pass_cnt++;
  endtask

  task automatic test_key();
    logic [31:0] d;
    int n;
    int k;
    int len;
    key_n[0] = 1'b0; repeat (D - 1) tick(); key_n[0] = 1'b1;
    repeat (10) tick();
    rd(BASE + 32'hC, d);
    chk_cnt++; if (d !== 32'h0) $display("FAIL glitch_key got=%h exp=0", d); else pass_cnt++;
    rd(BASE + 32'h10, d);
    chk_cnt++; if (d !== 32'h0) $display("FAIL glitch_edge got=%h exp=0", d); else pass_cnt++;
    wr(BASE + 32'h10, 32'h100); m_mask = 4'h1;
    key_n[0] = 1'b0;
    n = 0;
    while (irq !== 1'b1 && n < 20) begin tick(); n++; end
    m_edge = 4'h1;
    chk_cnt++; if (n !== 2 + D) $display("FAIL key_latency got=%0d exp=%0d", n, 2 + D); else pass_cnt++;
    rd(BASE + 32'hC, d);
    chk_cnt++; if (d !== 32'h1) $display("FAIL key_pressed got=%h exp=1", d); else pass_cnt++;
    rd(BASE + 32'h10, d);
    chk_cnt++; if (d !== model_read(4)) $display("FAIL key_edge got=%h exp=%h", d, model_read(4)); else pass_cnt++;
    wr(BASE + 32'h10, 32'h101); m_edge = 4'h0;
    chk_cnt++; if (irq !== 1'b0) $display("FAIL w1c_irq got=%b exp=0", irq); else pass_cnt++;
    rd(BASE + 32'h10, d);
    chk_cnt++; if (d !== model_read(4)) $display("FAIL w1c_edge got=%h exp=%h", d, model_read(4)); else pass_cnt++;
    key_n[0] = 1'b1; repeat (10) tick();
    rd(BASE + 32'h10, d);
    chk_cnt++; if (d !== model_read(4)) $display("FAIL release_edge got=%h exp=%h", d, model_read(4)); else pass_cnt++;
    // press of key1 lands on the same edge as a W1C of that flag
    key_n[1] = 1'b0;
    repeat (1 + D) tick();
    wr(BASE + 32'h10, 32'h102); m_edge = 4'h2;
    rd(BASE + 32'h10, d);
    chk_cnt++; if (d !== model_read(4)) $display("FAIL edge_set_wins got=%h exp=%h", d, model_read(4)); else pass_cnt++;
    chk_cnt++; if (irq !== 1'b0) $display("FAIL edge_unmasked_irq got=%b exp=0", irq); else pass_cnt++;
    key_n[1] = 1'b1; repeat (10) tick();
    wr(BASE + 32'h10, 32'hF); m_edge = 4'h0; m_mask = 4'h0;
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(0, 3);
      len = (it < 2) ? (D - 1 + it) : $urandom_range(1, 8);
      key_n[k] = 1'b0; repeat (len) tick(); key_n[k] = 1'b1;
      repeat (12) tick();
      if (len >= D) m_edge[k] = 1'b1;
      rd(BASE + 32'h10, d);
      chk_cnt++; if (d !== model_read(4)) $display("FAIL rand_edge key=%0d len=%0d got=%h exp=%h", k, len, d, model_read(4)); else pass_cnt++;
      m_mask = 4'($urandom_range(0, 15));
      wr(BASE + 32'h10, {20'h0, m_mask, 8'h0});
      chk_cnt++; if (irq !== |(m_edge & m_mask)) $display("FAIL rand_irq got=%b exp=%b", irq, |(m_edge & m_mask)); else pass_cnt++;
    end
    wr(BASE + 32'h10, 32'hF); m_edge = 4'h0; m_mask = 4'h0;
  endtask

  task automatic test_timer();
    logic [31:0] d;
`ifdef IO_MMIO_TIMER_EN
    int cmp;
    int m;
    int en_cyc;
    int n;
    cmp = $urandom_range(3, 12); m = cmp + 1;
    wr(BASE + 32'h18, 32'(cmp));
    wr(BASE + 32'h14, 32'h0);
    wr(BASE + 32'h1C, 32'h7); en_cyc = cyc;
    n = 0;
    while (irq !== 1'b1 && n < 40) begin tick(); n++; end
    chk_cnt++; if (n !== m) $display("FAIL tmr_match_latency got=%0d exp=%0d", n, m); else pass_cnt++;
    d = 32'((cyc - en_cyc) % m);
    rd(BASE + 32'h14, io_data_in);
    chk_cnt++; if (io_data_in !== d) $display("FAIL tmr_reload got=%h exp=%h", io_data_in, d); else pass_cnt++;
    rd(BASE + 32'h1C, d);
    chk_cnt++; if (d !== 32'hF) $display("FAIL tmr_ctrl got=%h exp=f", d); else pass_cnt++;
    if ((cyc - en_cyc) % m == cmp) tick();
    wr(BASE + 32'h1C, 32'hF);
    chk_cnt++; if (irq !== 1'b0) $display("FAIL tmr_w1c got=%b exp=0", irq); else pass_cnt++;
    n = 0;
    while ((cyc - en_cyc) % m != cmp && n < 40) begin tick(); n++; end
    wr(BASE + 32'h1C, 32'hF);
    chk_cnt++; if (irq !== 1'b1) $display("FAIL tmr_set_wins got=%b exp=1", irq); else pass_cnt++;
    wr(BASE + 32'h14, 32'd100);
    rd(BASE + 32'h14, d);
    chk_cnt++; if (d !== 32'd100) $display("FAIL tcount_write got=%0d exp=100", d); else pass_cnt++;
    rd(BASE + 32'h14, d);
    chk_cnt++; if (d !== 32'd101) $display("FAIL tcount_incr got=%0d exp=101", d); else pass_cnt++;
`else
    bit seen;
    wr(BASE + 32'h18, 32'h0);
    wr(BASE + 32'h1C, 32'h7);
    wr(BASE + 32'h14, 32'h5);
    rd(BASE + 32'h1C, d);
    chk_cnt++; if (d !== 32'h0) $display("FAIL notmr_ctrl got=%h exp=0", d); else pass_cnt++;
    rd(BASE + 32'h14, d);
    chk_cnt++; if (d !== 32'h0) $display("FAIL notmr_count got=%h exp=0", d); else pass_cnt++;
    seen = 1'b0;
    repeat (10) begin tick(); if (irq !== 1'b0) seen = 1'b1; end
    chk_cnt++; if (seen !== 1'b0) $display("FAIL notmr_irq got=%b exp=0", seen); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(BASE + 32'h8, 32'h155); wr(BASE, 32'h9876); wr(BASE + 32'h4, 32'h0);
    wr(BASE + 32'h10, 32'hF00);
    rd(BASE, d);
    RST = 1'b1; tick(); RST = 1'b0;
    model_reset();
    chk_cnt++; if (seven_seg_out !== 28'hFFFFFFF) $display("FAIL mid_rst_seg got=%h exp=fffffff", seven_seg_out); else pass_cnt++;
    chk_cnt++; if (led_out !== 26'h0) $display("FAIL mid_rst_led got=%h exp=0", led_out); else pass_cnt++;
    chk_cnt++; if (io_data_out !== 32'h0) $display("FAIL mid_rst_dout got=%h exp=0", io_data_out); else pass_cnt++;
    chk_cnt++; if (irq !== 1'b0) $display("FAIL mid_rst_irq got=%b exp=0", irq); else pass_cnt++;
    rd(BASE + 32'h10, d);
    chk_cnt++; if (d !== model_read(4)) $display("FAIL mid_rst_mask got=%h exp=%h", d, model_read(4)); else pass_cnt++;
    rd(BASE + 32'h14, d);
    chk_cnt++; if (d !== 32'h0) $display("FAIL mid_rst_tcount got=%h exp=0", d); else pass_cnt++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_hex();
    test_led();
    test_back_to_back();
    test_key();
    test_timer();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/io_mmio.md
# io_mmio

Parametrised memory-mapped I/O controller that replaces the fixed seven-segment/LED output block on the processor data bus. It decodes a 32-byte register window at `BASE_ADDR` and drives a configurable number of hex digits and LEDs. It debounces push-buttons and reports press edges, and provides an optional compare timer with an interrupt line. Reads are registered and returned to the processor's memory-stage read mux.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0100: byte address of register window; 32-byte aligned.
- `HEX_DIGITS`, 4: number of seven-segment digits (1–8).
- `LEDR_W`, 18: red LED count (1–24).
- `LEDG_W`, 8: green LED count; `LEDR_W + LEDG_W` ≤ 32.
- `KEY_W`, 4: push-button count (1–8).
- `DEBOUNCE_CYCLES`, 50000: stable samples required before a key change is accepted (≥ 1).

Ports:
- `CLK`  in  1  system clock.
- `RST`  in  1  synchronous, active-high reset.
- `io_addr`  in  32  byte address from the memory stage.
- `io_data_in`  in  32  write data.
- `io_w_en`  in  1  write strobe.
- `io_r_en`  in  1  read strobe.
- `io_hit`  out  1  combinational; `io_addr` is inside the window.
- `io_data_out`  out  32  registered read data.
- `key_n`  in  `KEY_W`  raw buttons, active-low, asynchronous.
- `seven_seg_out`  out  `7*HEX_DIGITS`  active-low segments; digit 0 is in the LSBs.
- `led_out`  out  `LEDR_W+LEDG_W`  `{LEDR, LEDG}`.
- `irq`  out  1  level interrupt.

## Operation
- All accesses are word accesses. `io_addr[1:0]` is ignored. The window offset is `io_addr[4:2]`.
- Register map (byte offset):
  - 0x00 HEX: nibble `i` is the value shown on digit `i`.
  - 0x04 BLANK: bit `i` = 1 blanks digit `i` (all segments off).
  - 0x08 LED: low `LEDG_W` bits drive LEDG; the next `LEDR_W` bits drive LEDR.
  - 0x0C KEY: read-only; debounced state, 1 = pressed.
  - 0x10 KEY_EDGE: sticky press flags, write-1-to-clear. Bits [15:8] are the IRQ mask (read/write).
  - 0x14 TCOUNT: timer count.
  - 0x18 TCMP: timer compare value.
  - 0x1C TCTRL: bit0 enable, bit1 auto-reload, bit2 irq-enable, bit3 match flag (write-1-to-clear).
- Unused bits read 0. Writes to read-only or unmapped offsets are ignored. Reads of unmapped offsets return 0.
- Debounce, per key:
  - Two-flop synchroniser, then a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - The counter resets whenever the synchronised input equals the debounced state.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced state toggles and the counter clears.
- A 0→1 transition of a debounced key sets its KEY_EDGE bit.
- Timer, when enabled:
  - TCOUNT increments every cycle and wraps at 2^32.
  - When TCOUNT == TCMP, the match flag is set. With auto-reload, the next value is 0 instead of TCMP+1.
- `irq` = `|(KEY_EDGE & mask)` | (match flag & irq-enable).
- Conflict rules:
  - A software write to TCOUNT wins over increment and reload.
  - A hardware set wins over a W1C clear in the same cycle, for both edge flags and the match flag.
  - A write with `io_addr` outside the window has no effect.

## Timing
- Reset values:
  - `seven_seg_out` all ones.
  - `led_out` 0, `io_data_out` 0, `irq` 0.
  - HEX 0, BLANK all ones, KEY and edge flags 0, mask 0.
  - TCOUNT 0, TCMP 32'hFFFF_FFFF, TCTRL 0, debounce counters 0.
- `RST` asserted mid-operation returns everything to reset values on that edge. Synchroniser flops also reset to "released".
- Writes commit on the `CLK` edge where `io_w_en && io_hit`.
- `seven_seg_out` and `led_out` are registered: they change on the edge after the write commits.
- Reads: `io_data_out` is valid one cycle after `io_r_en && io_hit`, and holds until the next read. A read outside the window loads 0.
- Key latency: 2 sync cycles + `DEBOUNCE_CYCLES` cycles to the KEY bit. The edge flag and `irq` follow on the same edge as the KEY bit.
- Timer match: the flag is set on the edge after the cycle where TCOUNT == TCMP. `irq` is registered from the flags.

## Configuration
- `IO_MMIO_TIMER_EN`:
  - Defined: timer registers and logic are present as described.
  - Undefined: offsets 0x14–0x1C read 0, writes are ignored, and the timer term of `irq` is constant 0.

## Structure
- Package `io_mmio_pkg`: register offset constants (`OFF_HEX` … `OFF_TCTRL`), TCTRL bit-index constants, and the 16-entry hex-to-segment constant table.
- Sub-module `key_debounce` (one instance per key via generate): synchroniser, counter, debounced output and rising-edge pulse.
- The segment decode is a function using the package table; it is not a separate module.

## Test plan
- Reset, then write 0x00000000 to BLANK and 0x00004321 to HEX → after 2 cycles, digits 3..0 show 4,3,2,1 (digit 0 = 7'b1111001). Read HEX → 0x00004321 one cycle after `io_r_en`.
- Write 0xFFFFFFFF to LED with default widths → `led_out` = 26'h3FFFFFF. Write at `BASE_ADDR+0x20` → no change and `io_hit`=0.
- With `DEBOUNCE_CYCLES`=4: glitch `key_n[0]` low for 3 cycles → KEY stays 0. Hold low for 10 cycles → KEY bit0 = 1 and edge bit0 = 1. With mask bit8 set, `irq` = 1. Write 0x101 to KEY_EDGE → flag clears and `irq` = 0.
- Timer (macro defined): TCMP=5, TCTRL=0b0111 → match flag set and `irq` = 1 after count 5, count restarts at 0. Simultaneous W1C and new match → flag stays 1.
- Write TCOUNT=100 while enabled → reads 100 the next cycle (write beats increment). Assert `RST` mid-count → all outputs at reset values the next cycle.
- Macro undefined: write TCTRL=1 → reads 0, and `irq` never asserts from the timer.
